// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace buffer: FSM states, trigger modes and entry width.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TRIG_IMM  = 2'd0,
        TRIG_PC   = 2'd1,
        TRIG_ZERO = 2'd2,
        TRIG_NEG  = 2'd3
    } trig_mode_t;

    // One entry holds {pc, instr, alu, zero, neg}.
    function automatic int entry_w(input int data_w);
        return 3 * data_w + 2;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: synchronous write, asynchronous read; contents are never reset.
// Zero-latency read, no flow control of its own.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 26,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular CPU trace capture with trigger and post-trigger window; readout in DONE.
// Samples written same cycle; readout is combinational valid/ready, held stable under backpressure.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic [1:0]                   trig_mode,
    input  logic [DATA_W-1:0]            trig_pc,
    input  logic                         sample_en,
    input  logic [DATA_W-1:0]            pc_in,
    input  logic [DATA_W-1:0]            instr_in,
    input  logic [DATA_W-1:0]            alu_in,
    input  logic                         zero_in,
    input  logic                         neg_in,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [entry_w(DATA_W)-1:0]   rd_data,
    output logic [1:0]                   state_o,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int             PW       = $clog2(DEPTH);
    localparam int             EW       = entry_w(DATA_W);
    localparam logic [PW:0]    FULL     = (PW+1)'(DEPTH);
    localparam logic [PW:0]    POST_LIM = (PW+1)'(POST_TRIG);
    localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    state_t        state, state_nx;
    logic [PW-1:0] wr_ptr, wr_nx, rd_ptr, rd_nx;
    logic [PW:0]   cnt_nx, post_cnt, post_nx, cnt_sat;
    logic          we, trig_hit, xfer;
    logic [EW-1:0] wr_entry;

    assign wr_entry = {pc_in, instr_in, alu_in, zero_in, neg_in};
    assign cnt_sat  = (count == FULL) ? FULL : count + CNT_ONE;
    assign rd_valid = (state == ST_DONE) && (count != '0);
    assign xfer     = rd_valid && rd_ready;
    assign state_o  = state;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode_t'(trig_mode))
            TRIG_IMM:  trig_hit = 1'b1;
            TRIG_PC:   trig_hit = (pc_in == trig_pc);
            TRIG_ZERO: trig_hit = zero_in;
            TRIG_NEG:  trig_hit = neg_in;
        endcase
    end

    always_comb begin
        state_nx = state;
        wr_nx    = wr_ptr;
        rd_nx    = rd_ptr;
        cnt_nx   = count;
        post_nx  = post_cnt;
        we       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nx = ST_ARMED;
                    wr_nx    = '0;
                    cnt_nx   = '0;
                end
            end
            ST_ARMED: begin
                if (sample_en) begin
                    we     = 1'b1;
                    wr_nx  = wr_ptr + PTR_ONE;
                    cnt_nx = cnt_sat;
                    if (trig_hit) begin
                        post_nx  = '0;
                        state_nx = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (sample_en) begin
                    we      = 1'b1;
                    wr_nx   = wr_ptr + PTR_ONE;
                    cnt_nx  = cnt_sat;
                    post_nx = post_cnt + CNT_ONE;
                    if (post_nx == POST_LIM) begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A re-arm wins over a same-cycle transfer.
                if (arm) begin
                    state_nx = ST_ARMED;
                    wr_nx    = '0;
                    cnt_nx   = '0;
                end else if (xfer) begin
                    rd_nx  = rd_ptr + PTR_ONE;
                    cnt_nx = count - CNT_ONE;
                    if (cnt_nx == '0) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
        endcase
        // Oldest surviving entry sits count slots behind the write pointer; a full buffer gives wr_ptr.
        if (state != ST_DONE && state_nx == ST_DONE) begin
            rd_nx = wr_nx - cnt_nx[PW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
        end else begin
            state    <= state_nx;
            wr_ptr   <= wr_nx;
            rd_ptr   <= rd_nx;
            count    <= cnt_nx;
            post_cnt <= post_nx;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed and randomized bench for cpu_trace_buffer against a queue-based capture model.
module tb_cpu_trace_buffer;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 8;
    localparam int EW        = 3 * DATA_W + 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n, arm, sample_en, zero_in, neg_in, rd_ready, rd_valid;
    logic [1:0]        trig_mode, state_o;
    logic [DATA_W-1:0] trig_pc, pc_in, instr_in, alu_in;
    logic [EW-1:0]     rd_data;
    logic [CW-1:0]     count;

    always #5 clk = ~clk;

    cpu_trace_buffer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .trig_mode (trig_mode),
        .trig_pc   (trig_pc),
        .sample_en (sample_en),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .alu_in    (alu_in),
        .zero_in   (zero_in),
        .neg_in    (neg_in),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .state_o   (state_o),
        .count     (count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: captured entries kept oldest-first in a queue.
    int            mstate    = 0;
    int            post_left = 0;
    logic [EW-1:0] mq[$];

    function automatic logic [31:0] pc_of(input logic [EW-1:0] e);
        return 32'(e[EW-1 -: DATA_W]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry();
        mq.push_back({pc_in, instr_in, alu_in, zero_in, neg_in});
        if (mq.size() > DEPTH) void'(mq.pop_front());
    endtask

    task automatic model_edge();
        bit hit;
        if (!rst_n) begin
            mstate = 0;
            mq.delete();
        end else begin
            case (mstate)
                0: if (arm) begin
                    mstate = 1;
                    mq.delete();
                end
                1: if (sample_en) begin
                    push_entry();
                    hit = (trig_mode == 2'd0) || (trig_mode == 2'd1 && pc_in == trig_pc) ||
                          (trig_mode == 2'd2 && zero_in) || (trig_mode == 2'd3 && neg_in);
                    if (hit) begin
                        post_left = POST_TRIG;
                        mstate    = (POST_TRIG == 0) ? 3 : 2;
                    end
                end
                2: if (sample_en) begin
                    push_entry();
                    post_left--;
                    if (post_left == 0) mstate = 3;
                end
                default: begin
                    if (arm) begin
                        mstate = 1;
                        mq.delete();
                    end else if (rd_ready && mq.size() > 0) begin
                        void'(mq.pop_front());
                        if (mq.size() == 0) mstate = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        bit v;
        model_edge();
        @(posedge clk);
        #1;
        v = (mstate == 3) && (mq.size() > 0);
        check("state", 32'(state_o), 32'(mstate));
        check("count", 32'(count), 32'(mq.size()));
        check("rd_valid", 32'(rd_valid), 32'(v));
        if (v) check("rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    task automatic sample(input logic [DATA_W-1:0] pc);
        sample_en = 1'b1;
        pc_in     = pc;
        instr_in  = 8'($urandom);
        alu_in    = 8'($urandom);
        zero_in   = 1'b0;
        neg_in    = 1'b0;
    endtask

    task automatic quiet();
        sample_en = 1'b0;
        arm       = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [DATA_W-1:0] tp);
        trig_mode = m;
        trig_pc   = tp;
        sample_en = 1'b0;
        arm       = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic drain(input int budget);
        rd_ready  = 1'b1;
        sample_en = 1'b0;
        for (int n = 0; n < budget && state_o != 2'd0; n++) cycle();
        check("drain_idle", 32'(state_o), 32'd0);
        rd_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; trig_mode = 2'd0; trig_pc = '0;
        sample_en = 1'b0; pc_in = '0; instr_in = '0; alu_in = '0;
        zero_in = 1'b0; neg_in = 1'b0; rd_ready = 1'b0;

        cycle();
        cycle();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;

        // Immediate trigger, 9 samples, in-order readout.
        do_arm(2'd0, 8'h00);
        for (int i = 0; i <= 8; i++) begin
            sample(8'(i));
            cycle();
        end
        quiet();
        check("m0_state", 32'(state_o), 32'd3);
        check("m0_count", 32'(count), 32'd9);
        rd_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            check("m0_order", pc_of(rd_data), 32'(i));
            cycle();
        end
        rd_ready = 1'b0;
        check("m0_idle", 32'(state_o), 32'd0);

        // PC-match trigger with wrap; late samples must not be stored.
        do_arm(2'd1, 8'h14);
        for (int i = 0; i < 32; i++) begin
            sample(8'(i));
            cycle();
        end
        quiet();
        check("m1_state", 32'(state_o), 32'd3);
        check("m1_count", 32'(count), 32'd16);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("m1_order", pc_of(rd_data), 32'(8'h0D + i));
            cycle();
        end
        rd_ready = 1'b0;
        check("m1_idle", 32'(state_o), 32'd0);

        // Zero-flag trigger with gapped samples, then readout backpressure.
        do_arm(2'd2, 8'h00);
        begin
            int            v;
            logic [7:0]    first;
            logic [EW-1:0] hold;
            v     = 0;
            first = '0;
            for (int n = 0; n < 100 && state_o != 2'd3; n++) begin
                if (n % 2 == 0) begin
                    sample(8'($urandom));
                    if (v == 0) first = pc_in;
                    zero_in = (v == 4);
                    v++;
                end else begin
                    sample_en = 1'b0;
                end
                cycle();
            end
            quiet();
            check("m2_state", 32'(state_o), 32'd3);
            check("m2_count", 32'(count), 32'd13);
            check("m2_oldest", pc_of(rd_data), 32'(first));
            rd_ready = 1'b0;
            hold     = rd_data;
            for (int k = 0; k < 3; k++) begin
                sample(8'($urandom));
                cycle();
                check("bp_valid", 32'(rd_valid), 32'd1);
                check("bp_hold", 32'(rd_data), 32'(hold));
            end
            quiet();
            rd_ready = 1'b1;
            for (int i = 13; i >= 1; i--) begin
                check("bp_count", 32'(count), 32'(i));
                cycle();
            end
            rd_ready = 1'b0;
            check("bp_idle", 32'(state_o), 32'd0);
        end

        // Reset during the post-trigger window, then a clean capture.
        do_arm(2'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            sample(8'(8'h40 + i));
            cycle();
        end
        quiet();
        check("mp_post", 32'(state_o), 32'd2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mp_state", 32'(state_o), 32'd0);
        check("mp_count", 32'(count), 32'd0);
        check("mp_valid", 32'(rd_valid), 32'd0);
        do_arm(2'd0, 8'h00);
        for (int i = 0; i <= 8; i++) begin
            sample(8'(8'h50 + i));
            cycle();
        end
        quiet();
        check("mp_recount", 32'(count), 32'd9);
        check("mp_oldest", pc_of(rd_data), 32'h50);
        drain(20);

        // arm ignored while armed; arm in DONE beats a same-cycle transfer.
        do_arm(2'd1, 8'hEE);
        for (int i = 1; i <= 3; i++) begin
            sample(8'(i));
            cycle();
        end
        sample_en = 1'b0;
        arm       = 1'b1;
        cycle();
        arm = 1'b0;
        check("ign_count", 32'(count), 32'd3);
        check("ign_state", 32'(state_o), 32'd1);
        sample(8'hEE);
        cycle();
        for (int i = 0; i < 8; i++) begin
            sample(8'(8'h60 + i));
            cycle();
        end
        quiet();
        check("rearm_done", 32'(state_o), 32'd3);
        check("rearm_count", 32'(count), 32'd12);
        rd_ready = 1'b1;
        cycle();
        check("rearm_xfer", 32'(count), 32'd11);
        arm = 1'b1;
        cycle();
        arm      = 1'b0;
        rd_ready = 1'b0;
        check("rearm_state", 32'(state_o), 32'd1);
        check("rearm_clear", 32'(count), 32'd0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;

        // Randomized captures with random backpressure, re-arms and resets.
        for (int r = 0; r < 40; r++) begin
            if (state_o != 2'd0) begin
                quiet();
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end
            do_arm(2'($urandom), 8'($urandom_range(0, 15)));
            for (int n = 0; n < 300 && state_o != 2'd0; n++) begin
                sample_en = ($urandom_range(0, 9) < 7);
                pc_in     = 8'($urandom_range(0, 15));
                instr_in  = 8'($urandom);
                alu_in    = 8'($urandom);
                zero_in   = ($urandom_range(0, 7) == 0);
                neg_in    = ($urandom_range(0, 7) == 0);
                rd_ready  = 1'($urandom_range(0, 1));
                arm       = ($urandom_range(0, 49) == 0);
                rst_n     = !($urandom_range(0, 199) == 0);
                cycle();
            end
            rst_n     = 1'b1;
            arm       = 1'b0;
            sample_en = 1'b0;
            rd_ready  = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of the pc, instruction and ALU sample fields.
REQ-002 Parameter DEPTH, default 16: number of trace entries; a power of two, at least 4.
REQ-003 Parameter POST_TRIG, default 8: number of samples captured after the trigger sample; range 0..DEPTH-1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 arm  in  1  one-cycle pulse that starts a capture.
REQ-007 trig_mode  in  2  trigger mode: 0 immediate, 1 pc match, 2 zero flag, 3 neg flag.
REQ-008 trig_pc  in  DATA_W  comparison value for mode 1.
REQ-009 sample_en  in  1  the CPU sample inputs are valid this cycle.
REQ-010 pc_in, instr_in, alu_in  in  DATA_W each  CPU pc, instruction and ALU result.
REQ-011 zero_in, neg_in  in  1 each  CPU zero and negative flags.
REQ-012 rd_valid  out  1  readout entry available.
REQ-013 rd_ready  in  1  consumer accepts the entry.
REQ-014 rd_data  out  3*DATA_W+2  entry packed as {pc, instr, alu, zero, neg}.
REQ-015 state_o  out  2  current state: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-016 count  out  clog2(DEPTH)+1  number of valid entries held.

Function
REQ-017 IDLE: no writes. On arm, go to ARMED and clear count and the write pointer.
REQ-018 ARMED: each sample_en cycle writes one entry at wr_ptr; wr_ptr wraps modulo DEPTH; count saturates at DEPTH.
REQ-019 Trigger evaluation happens only on sample_en cycles in ARMED:
  - mode 0: fires on the first sample;
  - mode 1: fires when pc_in==trig_pc;
  - mode 2: fires when zero_in==1;
  - mode 3: fires when neg_in==1.
REQ-020 The trigger sample is written in the same cycle it is detected. Next state is POST, or DONE if POST_TRIG==0.
REQ-021 POST: each sample_en cycle writes one entry. After POST_TRIG post samples, enter DONE on the following edge. A wrap overwrites the oldest entries, and count stays at DEPTH.
REQ-022 Cycles without sample_en write nothing and leave pointers and count unchanged, in every state.
REQ-023 DONE readout:
  - rd_ptr is initialised to (wr_ptr - count) mod DEPTH, the oldest entry;
  - rd_valid = (state==DONE && count>0);
  - rd_data = mem[rd_ptr], combinational and stable while rd_valid && !rd_ready.
REQ-024 A transfer occurs when rd_valid && rd_ready. Each transfer increments rd_ptr (wrapping) and decrements count. When count reaches 0, next state is IDLE.
REQ-025 arm is ignored in ARMED and POST. arm in DONE aborts the readout and restarts as in REQ-017; this takes priority over a same-cycle transfer.
REQ-026 sample_en is ignored in DONE; sampling never corrupts unread entries.

Reset
REQ-027 While rst_n==0 at a clock edge:
  - state_o = IDLE, and count, wr_ptr and rd_ptr = 0;
  - rd_valid = 0 on the following cycle;
  - reset mid-capture or mid-readout discards the capture.
  - Trace memory contents are not reset.

Structure
REQ-028 Package cpu_trace_pkg holds the state enum, the trig_mode enum, and the entry-width constant/function (3*DATA_W+2).
REQ-029 Memory is the sub-module trace_ram: DEPTH x entry width, synchronous write, asynchronous read.
REQ-030 The FSM, pointers and trigger logic live in cpu_trace_buffer.

Verification (DEPTH=16, POST_TRIG=8, DATA_W=8)
REQ-031 Mode 0, arm, continuous samples pc=0x00..0x08 -> state DONE after pc 0x08; count=9; readout returns pc 0x00..0x08 in order, then state IDLE.
REQ-032 Mode 1, trig_pc=0x14, continuous pc 0x00..0x1F -> trigger at 0x14; DONE after 0x1C; count=16; readout pc 0x0D..0x1C; samples 0x1D..0x1F not stored.
REQ-033 Mode 2, sample_en toggling 1/0, zero_in=1 on the 5th valid sample -> only valid cycles stored; count=13; oldest pc equals the first valid sample.
REQ-034 Backpressure: in DONE, hold rd_ready=0 for 3 cycles -> rd_valid=1 and rd_data constant throughout; then rd_ready=1 -> one entry per cycle; count decrements to 0; IDLE.
REQ-035 Reset mid-POST (after 3 post samples) with rst_n=0 for 1 cycle -> state IDLE, count=0, rd_valid=0; a subsequent arm captures correctly.
REQ-036 arm pulse in ARMED -> ignored, count unchanged. arm in DONE with rd_ready=1 the same cycle -> state ARMED, count=0, no transfer counted.
